// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sqrt / square datapaths.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int root_w(input int w);
        return w / 2;
    endfunction

    function automatic int rem_w(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/square_step.sv
// One shift-and-add iteration of the unsigned squarer.
module square_step
    import sqrt_pkg::*;
#(
    parameter int G_WIDTH = 8
) (
    input  logic [G_WIDTH-1:0]   acc,
    input  logic [G_WIDTH-1:0]   a,
    input  logic [G_WIDTH/2-1:0] m,
    output logic [G_WIDTH-1:0]   acc_nxt,
    output logic [G_WIDTH-1:0]   a_nxt,
    output logic [G_WIDTH/2-1:0] m_nxt
);

    localparam int N = root_w(G_WIDTH);

    always_comb begin
        acc_nxt = m[0] ? acc + a : acc;
        a_nxt   = a << 1;
        m_nxt   = m >> 1;
    end

endmodule

// File: rtl/square_pipe_seq.sv
// Iterative unsigned squarer, N = G_WIDTH/2 shift-add cycles per operand.
// Define SQUARE_REM_ADD_EN to add rem_in to the square (radicand rebuild).
module square_pipe_seq
    import sqrt_pkg::*;
#(
    parameter int G_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [G_WIDTH/2-1:0]   root_in,
`ifdef SQUARE_REM_ADD_EN
    input  logic [G_WIDTH/2:0]     rem_in,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [G_WIDTH-1:0]     data_out
);

    localparam int N  = root_w(G_WIDTH);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef logic [G_WIDTH-1:0] word_t;
    typedef logic [N-1:0]       root_t;

    state_t        state_q;
    state_t        state_d;
    word_t         acc_q;
    word_t         a_q;
    root_t         m_q;
    logic [CW-1:0] cnt_q;
    word_t         acc_n;
    word_t         a_n;
    root_t         m_n;
    word_t         acc_init;

    square_step #(
        .G_WIDTH (G_WIDTH)
    ) u_step (
        .acc     (acc_q),
        .a       (a_q),
        .m       (m_q),
        .acc_nxt (acc_n),
        .a_nxt   (a_n),
        .m_nxt   (m_n)
    );

`ifdef SQUARE_REM_ADD_EN
    assign acc_init = G_WIDTH'(rem_in);
`else
    assign acc_init = '0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)        state_d = BUSY;
            BUSY: if (cnt_q == LAST)   state_d = DONE;
            DONE: if (out_ready)       state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            a_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            data_out <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                acc_q <= acc_init;
                a_q   <= G_WIDTH'(root_in);
                m_q   <= root_in;
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                acc_q <= acc_n;
                a_q   <= a_n;
                m_q   <= m_n;
                cnt_q <= cnt_q + 1'b1;
                // last iteration lands straight in the output register
                if (cnt_q == LAST) begin
                    data_out <= acc_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_square_pipe_seq.sv
// Self-checking bench for square_pipe_seq (G_WIDTH = 8).
// Honours SQUARE_REM_ADD_EN when the DUT is built with it.
module tb_square_pipe_seq;

    localparam int GW = 8;
    localparam int N  = GW / 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  root_in;
    logic [N:0]    rem_in;
    logic          out_valid;
    logic          out_ready;
    logic [GW-1:0] data_out;

    int nvec;
    int nerr;

    square_pipe_seq #(
        .G_WIDTH (GW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .root_in   (root_in),
`ifdef SQUARE_REM_ADD_EN
        .rem_in    (rem_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    root;
        int    rem;
        int    exp;
        string tag;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int model(input int r, input int rm);
`ifdef SQUARE_REM_ADD_EN
        return (r * r + rm) % (1 << GW);
`else
        return r * r + 0 * rm;
`endif
    endfunction

    task automatic run_op(input int r, input int rm, input int exp,
                          input string tag);
        int lat;
        check({tag, "_rdy_pre"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        root_in  = N'(r);
        rem_in   = (N + 1)'(rm);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy_rdy"}, 32'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, N);
        check({tag, "_data"}, 32'(data_out), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_clr"}, 32'(out_valid), 0);
        check({tag, "_idle_rdy"}, 32'(in_ready), 1);
    endtask

    task automatic stream(input int nops, input bit rnd);
        int q[$];
        int sent;
        int got;
        int last_acc;
        int r;
        int e;
        bit acc;
        bit hs;
        sent     = 0;
        got      = 0;
        last_acc = -1;
        r        = rnd ? int'($urandom_range(0, (1 << N) - 1)) : 0;
        rem_in   = '0;
        for (int cyc = 0; cyc < nops * 20 && got < nops; cyc++) begin
            in_valid  = (sent < nops) &&
                        (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            root_in   = N'(r);
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (q.size() == 0) begin
                    check("stream_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check(rnd ? "rand_data" : "sweep_data",
                          32'(data_out), 32'(e));
                end
                got++;
            end
            if (acc) begin
                q.push_back(model(r, 0));
                if (!rnd && last_acc >= 0)
                    check("sweep_spacing", cyc - last_acc, N + 2);
                last_acc = cyc;
                sent++;
                r = rnd ? int'($urandom_range(0, (1 << N) - 1)) : r + 1;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check(rnd ? "rand_count" : "sweep_count", got, nops);
    endtask

    initial begin
        int lat;
        logic [GW-1:0] held;
        nvec = 0;
        nerr = 0;

`ifdef SQUARE_REM_ADD_EN
        tbl[0] = '{10, 7,  107, "rem_10_7"};
        tbl[1] = '{15, 30, 255, "rem_15_30"};
        tbl[2] = '{15, 0,  225, "rem_15_0"};
        tbl[3] = '{0,  0,  0,   "rem_0_0"};
        tbl[4] = '{3,  5,  14,  "rem_3_5"};
        tbl[5] = '{12, 24, 168, "rem_12_24"};
`else
        tbl[0] = '{15, 0, 225, "sq15"};
        tbl[1] = '{0,  0, 0,   "sq0"};
        tbl[2] = '{1,  0, 1,   "sq1"};
        tbl[3] = '{9,  0, 81,  "sq9"};
        tbl[4] = '{10, 0, 100, "sq10"};
        tbl[5] = '{5,  0, 25,  "sq5"};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        root_in   = '0;
        rem_in    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_data", 32'(data_out), 0);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_oready_noeffect", 32'(out_valid), 0);

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].root, tbl[i].rem, tbl[i].exp, tbl[i].tag);

        stream(16, 1'b0);
        tick();
        stream(40, 1'b1);
        tick();
        tick();

        // backpressure: root 9 held for 10 cycles
        in_valid = 1'b1;
        root_in  = 4'd9;
        rem_in   = '0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, N);
        held = data_out;
        check("bp_data", 32'(held), 81);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_data", 32'(data_out), 81);
            check("bp_hold_rdy", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_vld", 32'(out_valid), 0);
        check("bp_idle_rdy", 32'(in_ready), 1);

        // in_valid held high across a result
        in_valid = 1'b1;
        root_in  = 4'd7;
        tick();
        root_in  = 4'd3;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("hold_busy_rdy", 32'(in_ready), 0);
            tick();
            lat++;
        end
        check("hold_first", 32'(data_out), 49);
        tick();
        check("hold_done_rdy", 32'(in_ready), 0);
        check("hold_done_data", 32'(data_out), 49);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_idle_rdy", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("hold_accept_rdy", 32'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("hold_second_lat", lat, N);
        check("hold_second", 32'(data_out), 9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset in the middle of BUSY
        in_valid = 1'b1;
        root_in  = 4'd12;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_rdy", 32'(in_ready), 1);
        check("midrst_data", 32'(data_out), 0);
        check("midrst_vld", 32'(out_valid), 0);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) lat++;
        end
        check("midrst_no_result", lat, 0);
        check("midrst_still_idle", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/square_pipe_seq.md
Name: square_pipe_seq

Overview:
- Iterative unsigned squarer; the inverse direction of the team's pipelined `sqrt` block.
- Takes a G_WIDTH/2-bit root and produces its G_WIDTH-bit square.
- Used as a self-check / reconstruction path next to `sqrt`: feed it the root, compare the result against the original radicand.
- Shift-and-add over G_WIDTH/2 cycles; valid/ready handshake on both input and output.

Parameters:
- G_WIDTH, 8: output width; must be even and >= 4. Root width is N = G_WIDTH/2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  root_in valid.
- in_ready  out  1  block can accept an operand.
- root_in  in  G_WIDTH/2  unsigned root operand.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.
- data_out  out  G_WIDTH  unsigned result, root_in squared (plus rem_in when the optional feature is enabled).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; in_ready = 1; out_valid = 0; data_out = 0; internal accumulator and counter = 0.
  - Reset overrides everything, including mid-operation. An in-flight result is discarded; no partial out_valid.
- State IDLE:
  - in_ready = 1.
  - On the edge where in_valid && in_ready: latch multiplier m = root_in, multiplicand a = root_in zero-extended to G_WIDTH, acc = 0, cnt = 0; go to BUSY.
- State BUSY:
  - in_ready = 0; in_valid is ignored and must not disturb the operation.
  - Each edge: if m[0] = 1 then acc += a; then a <<= 1, m >>= 1, cnt += 1.
  - acc is G_WIDTH bits and never overflows, since (2^N - 1)^2 < 2^G_WIDTH.
  - On the edge where cnt reaches N-1, perform the final step, register data_out = final acc, assert out_valid, go to DONE.
- Latency: out_valid rises on the Nth rising edge after the accepting edge (N = 4 for G_WIDTH = 8).
- State DONE:
  - out_valid = 1; data_out stable and held while out_ready = 0 (unlimited backpressure).
  - On out_valid && out_ready: out_valid = 0 on that edge, go to IDLE.
  - in_ready stays 0 in DONE, so throughput is one operand per N + 2 cycles minimum.
- data_out keeps its last value after the handshake; it is only meaningful while out_valid = 1.
- Boundaries:
  - root_in = 0 gives 0.
  - root_in = all-ones gives (2^N - 1)^2.
  - in_valid held high across a result is accepted only in the next IDLE cycle.
  - out_ready high with out_valid low has no effect.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: SQUARE_REM_ADD_EN.
- Defined:
  - Adds input port rem_in, width G_WIDTH/2 + 1, latched with root_in on the accept edge.
  - acc is initialised to rem_in instead of 0, so data_out = root_in^2 + rem_in. This reconstructs the original radicand from the `sqrt` root and remainder.
  - Caller guarantees rem_in <= 2 * root_in, so the result fits in G_WIDTH bits. Larger values wrap modulo 2^G_WIDTH; no error flag.
- Undefined: no rem_in port; result is root_in^2 exactly.

Decomposition:
- Shared package sqrt_pkg:
  - State enum state_t {IDLE, BUSY, DONE}, 2-bit encoding.
  - Width helper functions: root width = w/2; remainder width = w/2 + 1.
- Parameter-dependent vector typedefs stay local to the module.
- One natural sub-module, square_step: combinational single shift-add iteration.
  - Inputs: acc, a, m.
  - Outputs: next acc, a, m.
  - Lets a future fully-pipelined variant instantiate it N times, mirroring the `sqrt` stage structure.

Test Plan (G_WIDTH = 8, N = 4):
- Reset, then root_in = 15 with in_valid pulse: out_valid rises 4 edges after accept, data_out = 225; in_ready is 0 from the accept edge until the output handshake.
- Sweep root_in 0..15 back-to-back with out_ready = 1: data_out = 0, 1, 4, ..., 225, in order, each exactly once, one result per 6 cycles.
- Hold out_ready = 0 for 10 cycles after root_in = 9: out_valid and data_out = 81 remain stable; handshake on the release cycle, IDLE the next cycle.
- Drive root_in = 3 with in_valid high during BUSY and DONE of an operation on root_in = 7: first result is 49; 3 is accepted only after return to IDLE and yields 9.
- Assert rst_n = 0 during BUSY (root_in = 12), release: out_valid never rises for 12; in_ready = 1 and data_out = 0 one edge after reset.
- With SQUARE_REM_ADD_EN: root_in = 10, rem_in = 7 gives data_out = 107; root_in = 15, rem_in = 30 gives data_out = 255.
